// File: rtl/program_loader.sv
// Boot loader: gathers a little-endian byte stream into 32-bit words, writes them
// sequentially into instruction memory, and releases the CPU once the load completes.
module program_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_req,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic                  abort,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [31:0]           imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, FINISH} state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH:0]   len_reg;
   logic [ADDR_WIDTH:0]   index_reg;
   logic [ADDR_WIDTH:0]   index_inc;
   logic [ADDR_WIDTH:0]   words_reg;
   logic [1:0]            byte_cnt_reg;
   logic [31:0]           asm_reg;
   logic                  cpu_start_reg;
   logic                  byte_acc;

   // A byte arriving alongside abort is dropped with the rest of the partial word.
   assign byte_acc  = (state_reg == RECV) && in_valid && !abort;
   assign index_inc = index_reg + 1'b1;

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      imem_we    = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (load_req)
               state_next = (len == '0) ? FINISH : RECV;
         end
         RECV: begin
            in_ready = 1'b1;
            if (abort)
               state_next = IDLE;
            else if (byte_acc && byte_cnt_reg == 2'd3)
               state_next = WRITE;
         end
         WRITE: begin
            imem_we = 1'b1;
            if (abort)
               state_next = IDLE;
            else if (index_inc == len_reg)
               state_next = FINISH;
            else
               state_next = RECV;
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         len_reg       <= '0;
         index_reg     <= '0;
         words_reg     <= '0;
         byte_cnt_reg  <= 2'd0;
         asm_reg       <= '0;
         cpu_start_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (load_req) begin
                  len_reg       <= len;
                  index_reg     <= '0;
                  words_reg     <= '0;
                  byte_cnt_reg  <= 2'd0;
                  cpu_start_reg <= 1'b0;
               end
            end
            RECV: begin
               if (abort) begin
                  byte_cnt_reg <= 2'd0;
               end else if (byte_acc) begin
                  asm_reg[{byte_cnt_reg, 3'b000} +: 8] <= in_data;
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
               end
            end
            WRITE: begin
               // The write happens even when aborted, so the word still counts.
               index_reg <= index_inc;
               words_reg <= words_reg + 1'b1;
            end
            FINISH: cpu_start_reg <= 1'b1;
            default: ;
         endcase
      end
   end

   assign imem_addr    = {{(32 - ADDR_WIDTH - 3){1'b0}}, index_reg, 2'b00};
   assign imem_wdata   = asm_reg;
   assign cpu_start    = cpu_start_reg;
   assign words_loaded = words_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, streaming, back-pressure, zero length,
// abort and a full-memory load, with writes and pulses logged by a negedge monitor.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_req;
   logic [8:0]  len;
   logic        abort;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_start;
   logic        busy;
   logic        done;
   logic [8:0]  words_loaded;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];
   int          done_cnt   = 0;
   int          done_cyc   = -1;
   int          rise_cyc   = -1;
   int          ready_viol = 0;
   logic        cpu_prev   = 1'b0;

   logic [7:0]  prog [12] = '{8'h13, 8'h00, 8'h50, 8'h00,
                              8'h93, 8'h00, 8'hA0, 8'h00,
                              8'h33, 8'h81, 8'h20, 8'h00};
   logic [31:0] exp_w [3] = '{32'h00500013, 32'h00A00093, 32'h00208133};

   program_loader #(.ADDR_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .load_req(load_req), .len(len), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_start(cpu_start), .busy(busy), .done(done), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
         wr_cyc.push_back(cyc);
         if (in_ready) ready_viol++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (cpu_start && !cpu_prev) rise_cyc = cyc;
      cpu_prev = cpu_start;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fm_word(input int w);
      logic [7:0] x;
      x = w[7:0];
      return {x, ~x, x ^ 8'h5A, x + 8'd1};
   endfunction

   // Called at a negedge; cycle 0 is the current cycle.
   task automatic start_load(input int n);
      load_req = 1'b1;
      len      = n[8:0];
      t0       = cyc;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b, input bit stall);
      bit acc;
      int guard;
      acc   = 1'b0;
      guard = 0;
      in_data = b;
      while (!acc && guard < 200) begin
         in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         acc = in_valid && in_ready;
         @(negedge clk);
         guard++;
      end
      if (!acc) chk("byte_accept_timeout", 32'(acc), 32'd1);
   endtask

   task automatic wait_done(input int base, input int limit);
      int k;
      k = 0;
      while (done_cnt <= base && k < limit) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("done_seen", 32'(done_cnt > base), 32'd1);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   initial begin
      int base;
      int dbase;
      rst = 1'b0; load_req = 1'b0; len = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_imem_we", 32'(imem_we), 32'd0);
      chk("rst_addr_data", imem_addr | imem_wdata, 32'd0);
      chk("rst_flags", {28'd0, cpu_start, busy, done, 1'b0}, 32'd0);
      chk("rst_words", 32'(words_loaded), 32'd0);

      // Asynchronous reset in the middle of a word.
      start_load(2);
      push_byte(8'h13, 1'b0);
      push_byte(8'h00, 1'b0);
      base = wr_addr.size();
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst_outputs", {in_ready, imem_we, cpu_start, busy, done, 27'd0}, 32'd0);
      chk("midrst_addr_data", imem_addr | imem_wdata, 32'd0);
      chk("midrst_words", 32'(words_loaded), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_no_write", 32'(wr_addr.size()), 32'(base));
      dbase = done_cnt;
      start_load(1);
      for (int i = 0; i < 4; i++) push_byte(prog[i], 1'b0);
      wait_done(dbase, 50);
      chk("postrst_count", 32'(wr_addr.size()), 32'(base + 1));
      chk("postrst_addr", wr_addr[base], 32'h0);
      chk("postrst_data", wr_data[base], 32'h00500013);

      // Continuous three-word stream with cycle-exact timing.
      base = wr_addr.size();
      dbase = done_cnt;
      start_load(3);
      for (int i = 0; i < 12; i++) push_byte(prog[i], 1'b0);
      wait_done(dbase, 50);
      chk("stream_count", 32'(wr_addr.size()), 32'(base + 3));
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stream_addr%0d", i), wr_addr[base + i], 32'(4 * i));
         chk($sformatf("stream_data%0d", i), wr_data[base + i], exp_w[i]);
         chk($sformatf("stream_cyc%0d", i), 32'(wr_cyc[base + i] - t0), 32'(5 * i + 5));
      end
      chk("stream_done_cyc", 32'(done_cyc - t0), 32'd16);
      chk("stream_start_cyc", 32'(rise_cyc - t0), 32'd17);
      chk("stream_words", 32'(words_loaded), 32'd3);
      chk("stream_cpu_start", 32'(cpu_start), 32'd1);

      // Same stream under random back-pressure.
      base = wr_addr.size();
      dbase = done_cnt;
      ready_viol = 0;
      start_load(3);
      for (int i = 0; i < 12; i++) push_byte(prog[i], 1'b1);
      wait_done(dbase, 400);
      chk("bp_count", 32'(wr_addr.size()), 32'(base + 3));
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp_addr%0d", i), wr_addr[base + i], 32'(4 * i));
         chk($sformatf("bp_data%0d", i), wr_data[base + i], exp_w[i]);
      end
      chk("bp_ready_in_write", 32'(ready_viol), 32'd0);
      chk("bp_words", 32'(words_loaded), 32'd3);

      // Zero-length load while the CPU is running.
      base = wr_addr.size();
      dbase = done_cnt;
      chk("zero_pre_start", 32'(cpu_start), 32'd1);
      load_req = 1'b1;
      len = '0;
      t0 = cyc;
      @(posedge clk);
      #1;
      chk("zero_start_falls", 32'(cpu_start), 32'd0);
      @(negedge clk);
      load_req = 1'b0;
      wait_done(dbase, 20);
      chk("zero_done_cyc", 32'(done_cyc - t0), 32'd1);
      chk("zero_start_cyc", 32'(rise_cyc - t0), 32'd2);
      chk("zero_no_write", 32'(wr_addr.size()), 32'(base));
      chk("zero_done_once", 32'(done_cnt), 32'(dbase + 1));

      // Abort after six bytes of a four-word load.
      base = wr_addr.size();
      dbase = done_cnt;
      start_load(4);
      for (int i = 0; i < 6; i++) push_byte(prog[i], 1'b0);
      in_valid = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("abort_count", 32'(wr_addr.size()), 32'(base + 1));
      chk("abort_addr", wr_addr[base], 32'h0);
      chk("abort_data", wr_data[base], 32'h00500013);
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_no_done", 32'(done_cnt), 32'(dbase));
      chk("abort_cpu_held", 32'(cpu_start), 32'd0);
      chk("abort_words", 32'(words_loaded), 32'd1);
      base = wr_addr.size();
      start_load(1);
      for (int i = 4; i < 8; i++) push_byte(prog[i], 1'b0);
      wait_done(dbase, 50);
      chk("reload_data", wr_data[base], 32'h00A00093);
      chk("reload_addr", wr_addr[base], 32'h0);
      chk("reload_start", 32'(cpu_start), 32'd1);

      // Full 256-word memory with an ignored mid-load request.
      base = wr_addr.size();
      dbase = done_cnt;
      start_load(256);
      for (int w = 0; w < 256; w++) begin
         logic [31:0] word;
         word = fm_word(w);
         for (int b = 0; b < 4; b++) begin
            if (w == 100 && b == 0) begin
               load_req = 1'b1;
               len = 9'd1;
            end
            push_byte(word[8 * b +: 8], 1'b0);
            load_req = 1'b0;
         end
      end
      wait_done(dbase, 50);
      chk("full_count", 32'(wr_addr.size()), 32'(base + 256));
      for (int w = 0; w < 256; w++) begin
         chk($sformatf("full_addr%0d", w), wr_addr[base + w], 32'(4 * w));
         chk($sformatf("full_data%0d", w), wr_data[base + w], fm_word(w));
      end
      chk("full_last_addr", wr_addr[base + 255], 32'h3FC);
      chk("full_done_once", 32'(done_cnt), 32'(dbase + 1));
      chk("full_words", 32'(words_loaded), 32'd256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
